// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, threshold flags, sticky errors, optional FWFT read.
// Define SYNC_FIFO_PEAK_EN to build the peak_count high-water-mark register (otherwise tied to 0).
module sync_fifo_flags #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned DEPTH         = 32,
    parameter int unsigned AFULL_THRESH  = 28,
    parameter int unsigned AEMPTY_THRESH = 4,
    parameter int unsigned FWFT          = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    err_clr,
    output logic [$clog2(DEPTH):0]  peak_count
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_flags: DEPTH must be a power of two and >= 4");
        end
        if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH - 1)) begin : g_bad_afull
            $error("sync_fifo_flags: AFULL_THRESH must be in 1..DEPTH-1");
        end
        if ((AEMPTY_THRESH < 1) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
            $error("sync_fifo_flags: AEMPTY_THRESH must be in 1..DEPTH-1");
        end
    endgenerate

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [ADDR_W-1:0]     w_rd_addr;

    // Flags decode the registered count; a read while full frees the slot the write lands in.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_rd_ok   = rd_en && !w_empty;
    assign w_wr_ok   = wr_en && (!w_full || rd_en);
    assign w_wr_addr = r_wr_ptr[ADDR_W-1:0];
    assign w_rd_addr = r_rd_ptr[ADDR_W-1:0];

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CNT_W'(AFULL_THRESH));
    assign almost_empty = (r_count <= CNT_W'(AEMPTY_THRESH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk or negedge rst_n) begin : ptr_count
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin : mem_write
        if (w_wr_ok) begin
            r_mem[w_wr_addr] <= data_in;
        end
    end

    // Sticky errors: a new event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin : err_flags
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full && !rd_en) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = r_mem[w_rd_addr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;

            always_ff @(posedge clk or negedge rst_n) begin : rd_reg
                if (!rst_n) begin
                    r_data_out <= '0;
                end else if (w_rd_ok) begin
                    r_data_out <= r_mem[w_rd_addr];
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

`ifdef SYNC_FIFO_PEAK_EN
    logic [CNT_W-1:0] r_peak;

    always_ff @(posedge clk or negedge rst_n) begin : peak_reg
        if (!rst_n) begin
            r_peak <= '0;
        end else if (err_clr) begin
            r_peak <= '0;
        end else if (r_count > r_peak) begin
            r_peak <= r_count;
        end
    end

    assign peak_count = r_peak;
`else
    assign peak_count = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: scoreboard bench for sync_fifo_flags (standard instance plus an FWFT instance).
module tb_sync_fifo_flags;

    localparam int unsigned DW    = 16;
    localparam int          DEPTH = 32;
    localparam int          AF    = 28;
    localparam int          AE    = 4;
    localparam int unsigned CW    = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, rd_en, err_clr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0] count, peak_count;

    logic          f_wr_en, f_rd_en, f_err_clr;
    logic [DW-1:0] f_data_in, f_data_out;
    logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [CW-1:0] f_count, f_peak;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_dout;
    bit            m_ovf, m_udf;
    int            m_max;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                      .AEMPTY_THRESH(AE), .FWFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr), .peak_count(peak_count)
    );

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                      .AEMPTY_THRESH(AE), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
        .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_afull),
        .almost_empty(f_aempty), .count(f_count), .overflow(f_ovf),
        .underflow(f_udf), .err_clr(f_err_clr), .peak_count(f_peak)
    );

    // Expected {full, empty, almost_full, almost_empty, overflow, underflow} from the model.
    function automatic logic [5:0] exp_flags();
        int n;
        n = m_q.size();
        return {(n == DEPTH), (n == 0), (n >= AF), (n <= AE), m_ovf, m_udf};
    endfunction

    function automatic logic [5:0] dut_flags();
        return {full, empty, almost_full, almost_empty, overflow, underflow};
    endfunction

    // Apply one cycle of stimulus; accepted reads push their expected word to exp_q.
    task automatic drive(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
        bit full_m, empty_m, rd_ok, wr_ok;
        full_m  = (m_q.size() == DEPTH);
        empty_m = (m_q.size() == 0);
        rd_ok   = rd && !empty_m;
        wr_ok   = wr && (!full_m || rd);
        wr_en = wr; data_in = d; rd_en = rd; err_clr = clr;
        if (rd_ok) exp_q.push_back(m_q.pop_front());
        if (wr_ok) m_q.push_back(d);
        if (wr && full_m && !rd) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (rd && empty_m) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
        if (clr) m_max = m_q.size(); else if (m_q.size() > m_max) m_max = m_q.size();
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        if (exp_q.size() > 0) m_dout = exp_q.pop_front();
    endtask

    task automatic model_clear();
        m_q.delete(); exp_q.delete();
        m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0; m_max = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0; f_data_in = '0;
        model_clear();
        #12;
        n_vec++;
        if (count !== CW'(0)) begin
            n_err++; $display("FAIL reset_count got %0d exp 0", count);
        end
        n_vec++;
        if (dut_flags() !== 6'b010100) begin
            n_err++; $display("FAIL reset_flags got %b exp 010100", dut_flags());
        end
        n_vec++;
        if (data_out !== '0) begin
            n_err++; $display("FAIL reset_dout got %h exp 0000", data_out);
        end
        n_vec++;
        if (peak_count !== CW'(0)) begin
            n_err++; $display("FAIL reset_peak got %0d exp 0", peak_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, DW'(i), 1'b0, 1'b0);
            n_vec++;
            if (count !== CW'(i + 1)) begin
                n_err++; $display("FAIL fill_count wr %0d got %0d exp %0d", i, count, i + 1);
            end
            n_vec++;
            if (dut_flags() !== exp_flags()) begin
                n_err++; $display("FAIL fill_flags wr %0d got %b exp %b", i, dut_flags(), exp_flags());
            end
        end
        n_vec++;
        if (full !== 1'b1) begin
            n_err++; $display("FAIL fill_full got %b exp 1", full);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            n_vec++;
            if (data_out !== DW'(i) || data_out !== m_dout) begin
                n_err++; $display("FAIL drain_data rd %0d got %h exp %h", i, data_out, DW'(i));
            end
        end
        n_vec++;
        if (dut_flags() !== 6'b010100 || count !== CW'(0)) begin
            n_err++; $display("FAIL drain_empty got flags %b count %0d exp 010100 / 0", dut_flags(), count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
        drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
        n_vec++;
        if (overflow !== 1'b1 || count !== CW'(32)) begin
            n_err++; $display("FAIL ovf_set got ovf %b count %0d exp 1 / 32", overflow, count);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        n_vec++;
        if (dut_flags() !== exp_flags() || overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_clr got %b exp %b", dut_flags(), exp_flags());
        end
    endtask

    task automatic test_full_rw();
        drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
        n_vec++;
        if (count !== CW'(32) || full !== 1'b1) begin
            n_err++; $display("FAIL full_rw_count got %0d full %b exp 32 / 1", count, full);
        end
        n_vec++;
        if (data_out !== 16'h0100) begin
            n_err++; $display("FAIL full_rw_oldest got %h exp 0100", data_out);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            n_vec++;
            if (data_out !== m_dout) begin
                n_err++; $display("FAIL full_rw_drain rd %0d got %h exp %h", i, data_out, m_dout);
            end
        end
        n_vec++;
        if (data_out !== 16'hBEEF || empty !== 1'b1) begin
            n_err++; $display("FAIL full_rw_newest got %h empty %b exp beef / 1", data_out, empty);
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_vec++;
        if (underflow !== 1'b1 || count !== CW'(0)) begin
            n_err++; $display("FAIL udf_set got udf %b count %0d exp 1 / 0", underflow, count);
        end
        drive(1'b1, 16'h1234, 1'b1, 1'b0);
        n_vec++;
        if (count !== CW'(1) || data_out !== 16'hBEEF) begin
            n_err++; $display("FAIL empty_rw got count %0d dout %h exp 1 / beef", count, data_out);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        n_vec++;
        if (data_out !== 16'h1234 || count !== CW'(0)) begin
            n_err++; $display("FAIL empty_rw_kept got %h count %0d exp 1234 / 0", data_out, count);
        end
        drive(1'b0, '0, 1'b1, 1'b1);
        n_vec++;
        if (underflow !== 1'b1) begin
            n_err++; $display("FAIL udf_set_wins got %b exp 1", underflow);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        n_vec++;
        if (dut_flags() !== exp_flags() || underflow !== 1'b0) begin
            n_err++; $display("FAIL udf_clr got %b exp %b", dut_flags(), exp_flags());
        end
    endtask

    task automatic test_fwft();
        f_wr_en = 1'b1; f_data_in = 16'hA5A5;
        @(posedge clk); #1; f_wr_en = 1'b0;
        n_vec++;
        if (f_empty !== 1'b0 || f_data_out !== 16'hA5A5) begin
            n_err++; $display("FAIL fwft_first got empty %b dout %h exp 0 / a5a5", f_empty, f_data_out);
        end
        f_wr_en = 1'b1; f_data_in = 16'h5A5A;
        @(posedge clk); #1; f_wr_en = 1'b0;
        n_vec++;
        if (f_data_out !== 16'hA5A5 || f_count !== CW'(2)) begin
            n_err++; $display("FAIL fwft_hold got %h count %0d exp a5a5 / 2", f_data_out, f_count);
        end
        f_rd_en = 1'b1;
        @(posedge clk); #1; f_rd_en = 1'b0;
        n_vec++;
        if (f_data_out !== 16'h5A5A || f_count !== CW'(1)) begin
            n_err++; $display("FAIL fwft_pop got %h count %0d exp 5a5a / 1", f_data_out, f_count);
        end
        f_rd_en = 1'b1;
        @(posedge clk); #1; f_rd_en = 1'b0;
        n_vec++;
        if (f_empty !== 1'b1) begin
            n_err++; $display("FAIL fwft_empty got %b exp 1", f_empty);
        end
    endtask

    task automatic test_random_wrap();
        int wr_pct, rd_pct;
        logic [CW-1:0] exp_peak;
        rst_n = 1'b0; model_clear();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) begin
            if (i < 60)       begin wr_pct = 85; rd_pct = 30; end
            else if (i < 140) begin wr_pct = 50; rd_pct = 50; end
            else              begin wr_pct = 25; rd_pct = 75; end
            drive(($urandom_range(0, 99) < wr_pct), DW'($urandom), ($urandom_range(0, 99) < rd_pct), 1'b0);
            n_vec++;
            if (count !== CW'(m_q.size()) || dut_flags() !== exp_flags()) begin
                n_err++;
                $display("FAIL rnd_state cyc %0d got count %0d flags %b exp %0d / %b",
                         i, count, dut_flags(), m_q.size(), exp_flags());
            end
            n_vec++;
            if (data_out !== m_dout) begin
                n_err++; $display("FAIL rnd_data cyc %0d got %h exp %h", i, data_out, m_dout);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
`ifdef SYNC_FIFO_PEAK_EN
        exp_peak = CW'(m_max);
`else
        exp_peak = '0;
`endif
        n_vec++;
        if (peak_count !== exp_peak) begin
            n_err++; $display("FAIL rnd_peak got %0d exp %0d", peak_count, exp_peak);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, DW'(16'h0F00 + i), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (count !== CW'(0) || empty !== 1'b1 || data_out !== '0) begin
            n_err++; $display("FAIL async_rst got count %0d empty %b dout %h exp 0 / 1 / 0000",
                              count, empty, data_out);
        end
        model_clear();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 16'h7777, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        n_vec++;
        if (data_out !== 16'h7777 || count !== CW'(0)) begin
            n_err++; $display("FAIL post_rst got %h count %0d exp 7777 / 0", data_out, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_fwft();
        test_random_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
